// File: rtl/wdog_pkg.sv
// Shared types for the windowed motor watchdog: FSM states and trip-cause codes.
package wdog_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TRIP = 2'd2
  } state_e;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
  localparam logic [1:0] CAUSE_EARLY   = 2'b10;

endpackage

// File: rtl/sync2.sv
// Generic two-flop level synchroniser with synchronous active-low clear.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/wdog_window_timer.sv
// Windowed motor watchdog: counts prescaled ticks in RUN, trips on timeout or early kick,
// latches the cause and gates the motor enable until the trip is cleared.
module wdog_window_timer
  import wdog_pkg::*;
#(
  parameter int              CNTW      = 16,
  parameter int              WINDOW_EN = 1,
  parameter logic [CNTW-1:0] TO_RST    = {CNTW{1'b1}},
  parameter logic [CNTW-1:0] WIN_RST   = '0
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            cein,
  input  logic            enable,
  input  logic            wdogdis,
  input  logic            kick,
  input  logic            clrtrip,
  input  logic            timeoutld,
  input  logic            windowld,
  input  logic [CNTW-1:0] wrtdata,
  output logic            motorenaint,
  output logic            wdtripce,
  output logic            tripped,
  output logic [1:0]      tripcause,
  output logic [CNTW-1:0] count
);

  state_e          state_q, state_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [CNTW-1:0] timeout_q, timeout_d;
  logic [CNTW-1:0] window_q, window_d;
  logic            tripped_q, tripped_d;
  logic [1:0]      cause_q, cause_d;
  logic            wdtripce_q, wdtripce_d;
  logic            motorena_q, motorena_d;
  logic            wdogdis_s;
  logic            early_kick;
  logic            regs_unlocked;

  sync2 #(.W(1)) u_dis_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (wdogdis),
    .q      (wdogdis_s)
  );

  assign early_kick    = (WINDOW_EN != 0) && (count_q < window_q);
  assign regs_unlocked = (state_q != RUN);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    tripped_d  = tripped_q;
    cause_d    = cause_q;
    wdtripce_d = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (enable && !wdogdis_s) state_d = RUN;
      end
      RUN: begin
        if (!enable || wdogdis_s) begin
          state_d = IDLE;
          count_d = '0;
        end else if (kick) begin
          if (early_kick) begin
            state_d    = TRIP;
            tripped_d  = 1'b1;
            cause_d    = CAUSE_EARLY;
            wdtripce_d = 1'b1;
          end else begin
            count_d = '0;
          end
        end else if (cein) begin
          // Trip on equality before incrementing, so the counter can never wrap.
          if (count_q == timeout_q) begin
            state_d    = TRIP;
            tripped_d  = 1'b1;
            cause_d    = CAUSE_TIMEOUT;
            wdtripce_d = 1'b1;
          end else begin
            count_d = count_q + CNTW'(1);
          end
        end
      end
      TRIP: begin
        if (clrtrip) begin
          state_d   = IDLE;
          count_d   = '0;
          tripped_d = 1'b0;
          cause_d   = CAUSE_NONE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // Limit registers are frozen while the motor runs.
  assign timeout_d  = (timeoutld && regs_unlocked) ? wrtdata : timeout_q;
  assign window_d   = (windowld && regs_unlocked) ? wrtdata : window_q;
  assign motorena_d = enable && (state_d != TRIP);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      count_q    <= '0;
      timeout_q  <= TO_RST;
      window_q   <= WIN_RST;
      tripped_q  <= 1'b0;
      cause_q    <= CAUSE_NONE;
      wdtripce_q <= 1'b0;
      motorena_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      timeout_q  <= timeout_d;
      window_q   <= window_d;
      tripped_q  <= tripped_d;
      cause_q    <= cause_d;
      wdtripce_q <= wdtripce_d;
      motorena_q <= motorena_d;
    end
  end

  assign motorenaint = motorena_q;
  assign wdtripce    = wdtripce_q;
  assign tripped     = tripped_q;
  assign tripcause   = cause_q;
  assign count       = count_q;

endmodule
